// File: rtl/alarm_zone_ctrl.sv
// Multi-zone armed alarm controller.
// Synchronises and debounces the sensor lines, runs the arm / entry-delay /
// alarm state machine, latches the zones that tripped while armed and holds
// the alarm until a disarm request arrives.
module alarm_zone_ctrl #(
  parameter int N_ZONES      = 4,
  parameter int DEBOUNCE_CYC = 4,
  parameter int ENTRY_DLY    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_ZONES-1:0] sensor,
  input  logic [N_ZONES-1:0] instant_mask,
  input  logic               arm,
  input  logic               disarm,
  output logic [N_ZONES-1:0] active,
  output logic [N_ZONES-1:0] zone,
  output logic               armed,
  output logic               entry,
  output logic               alarm
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam int TW = $clog2(ENTRY_DLY + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYC);
  localparam logic [TW-1:0] TMR_LOAD = TW'(ENTRY_DLY - 1);

  typedef enum logic [1:0] {
    ST_DISARMED,
    ST_ARMED,
    ST_ENTRY,
    ST_ALARM
  } state_t;

  state_t             state, state_nxt;
  logic [TW-1:0]      timer, timer_nxt;

  logic [N_ZONES-1:0] sensor_meta, sensor_s;
  logic               arm_meta, arm_s;
  logic               disarm_meta, disarm_s;

  logic [CW-1:0]      cnt [N_ZONES];
  logic [N_ZONES-1:0] trip_i, trip_d;

  // Two-flop synchronisers for every asynchronous input line.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state always uses non-blocking assignment so every flop
    // samples the pre-edge value of its neighbours, exactly like the hardware.
    if (!rst_n) begin
      sensor_meta <= '0;
      sensor_s    <= '0;
      arm_meta    <= 1'b0;
      arm_s       <= 1'b0;
      disarm_meta <= 1'b0;
      disarm_s    <= 1'b0;
    end else begin
      sensor_meta <= sensor;
      sensor_s    <= sensor_meta;
      arm_meta    <= arm;
      arm_s       <= arm_meta;
      disarm_meta <= disarm;
      disarm_s    <= disarm_meta;
    end
  end

  // Per-zone saturating debounce counters; any synced-low sample restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is a handful of flops, not a RAM, so it can and must
      // be reset; a real memory would be left out of the reset branch.
      for (int i = 0; i < N_ZONES; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_ZONES; i++) begin
        if (!sensor_s[i])          cnt[i] <= '0;
        else if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // A zone is active once its counter has saturated.
  always_comb begin
    active = '0;
    for (int i = 0; i < N_ZONES; i++) active[i] = (cnt[i] == CNT_MAX);
  end

  assign trip_i = active & instant_mask;
  assign trip_d = active & ~instant_mask;

  // State and entry-timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_DISARMED;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // Next-state logic; a synced disarm overrides everything else.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    state_nxt = state;
    timer_nxt = timer;
    unique case (state)
      ST_DISARMED: begin
        if (!disarm_s && arm_s && (active == '0)) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (disarm_s) begin
          state_nxt = ST_DISARMED;
        end else if (|trip_i) begin
          state_nxt = ST_ALARM;
        end else if (|trip_d) begin
          state_nxt = ST_ENTRY;
          timer_nxt = TMR_LOAD;
        end
      end
      ST_ENTRY: begin
        if (disarm_s) begin
          state_nxt = ST_DISARMED;
          timer_nxt = '0;
        end else if (|trip_i) begin
          state_nxt = ST_ALARM;
        end else if (timer == '0) begin
          state_nxt = ST_ALARM;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      ST_ALARM: begin
        if (disarm_s) state_nxt = ST_DISARMED;
      end
      default: state_nxt = ST_DISARMED;
    endcase
  end

  // Trip latch: accumulates active zones while armed, cleared on disarm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zone <= '0;
    end else if (state != ST_DISARMED) begin
      if (disarm_s) zone <= '0;
      else          zone <= zone | active;
    end
  end

  // Status outputs decoded from the registered state.
  assign armed = (state == ST_ARMED) || (state == ST_ENTRY);
  assign entry = (state == ST_ENTRY);
  assign alarm = (state == ST_ALARM);

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Self-checking bench for alarm_zone_ctrl: directed scenarios followed by a
// randomized run, all outputs compared every cycle against a behavioural model.
module tb_alarm_zone_ctrl;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int DLY = 16;

  localparam int M_OFF   = 0;
  localparam int M_ARMED = 1;
  localparam int M_ENTRY = 2;
  localparam int M_ALARM = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] sensor;
  logic [N-1:0] instant_mask;
  logic         arm;
  logic         disarm;
  logic [N-1:0] active;
  logic [N-1:0] zone;
  logic         armed;
  logic         entry;
  logic         alarm;

  int checks = 0;
  int errors = 0;

  alarm_zone_ctrl #(
    .N_ZONES     (N),
    .DEBOUNCE_CYC(DEB),
    .ENTRY_DLY   (DLY)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sensor      (sensor),
    .instant_mask(instant_mask),
    .arm         (arm),
    .disarm      (disarm),
    .active      (active),
    .zone        (zone),
    .armed       (armed),
    .entry       (entry),
    .alarm       (alarm)
  );

  always #5 clk = ~clk;

  // Reference model: raw-input history, run lengths of consecutive synced-high
  // samples, a mode and the number of cycles spent waiting in entry.
  logic [N-1:0] h_sens [2];
  logic         h_arm  [2];
  logic         h_dis  [2];
  int           run    [N];
  int           mode;
  int           elapsed;
  logic [N-1:0] m_zone;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [N-1:0] m_active();
    logic [N-1:0] a;
    a = '0;
    for (int i = 0; i < N; i++) a[i] = (run[i] >= DEB);
    return a;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      h_sens[k] = '0;
      h_arm[k]  = 1'b0;
      h_dis[k]  = 1'b0;
    end
    for (int i = 0; i < N; i++) run[i] = 0;
    mode    = M_OFF;
    elapsed = 0;
    m_zone  = '0;
  endtask

  // One clock edge of the model, using the inputs present just before it.
  task automatic model_edge();
    logic [N-1:0] s_now, act, ti, td;
    logic         a_now, d_now;
    s_now = h_sens[0];
    a_now = h_arm[0];
    d_now = h_dis[0];
    act   = m_active();
    ti    = act & instant_mask;
    td    = act & ~instant_mask;

    if (mode != M_OFF) m_zone = d_now ? '0 : (m_zone | act);

    case (mode)
      M_OFF:   if (!d_now && a_now && act == '0) mode = M_ARMED;
      M_ARMED: begin
        if (d_now)        mode = M_OFF;
        else if (|ti)     mode = M_ALARM;
        else if (|td) begin
          mode    = M_ENTRY;
          elapsed = 1;
        end
      end
      M_ENTRY: begin
        if (d_now)               mode = M_OFF;
        else if (|ti)            mode = M_ALARM;
        else if (elapsed >= DLY) mode = M_ALARM;
        else                     elapsed++;
      end
      default: if (d_now) mode = M_OFF;
    endcase

    for (int i = 0; i < N; i++)
      run[i] = s_now[i] ? ((run[i] < DEB) ? run[i] + 1 : DEB) : 0;

    h_sens[0] = h_sens[1];  h_sens[1] = sensor;
    h_arm[0]  = h_arm[1];   h_arm[1]  = arm;
    h_dis[0]  = h_dis[1];   h_dis[1]  = disarm;
  endtask

  task automatic compare_all();
    check("active", 32'(active), 32'(m_active()));
    check("zone",   32'(zone),   32'(m_zone));
    check("armed",  32'(armed),  32'(mode == M_ARMED || mode == M_ENTRY));
    check("entry",  32'(entry),  32'(mode == M_ENTRY));
    check("alarm",  32'(alarm),  32'(mode == M_ALARM));
  endtask

  // Advance one edge; inputs change only at edge+1 so the sample is clean.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic arm_sys();
    disarm = 1'b0;
    arm    = 1'b1;
    repeat (3) cycle();
    arm    = 1'b0;
  endtask

  task automatic release_all();
    sensor = '0;
    arm    = 1'b0;
    disarm = 1'b1;
    repeat (4) cycle();
    disarm = 1'b0;
    repeat (2) cycle();
  endtask

  initial begin
    sensor       = '0;
    instant_mask = '0;
    arm          = 1'b0;
    disarm       = 1'b0;
    do_reset();

    // 1: arming with all zones quiet takes three edges
    arm = 1'b1;
    repeat (2) cycle();
    check("t1_armed_early", 32'(armed), 32'd0);
    cycle();
    arm = 1'b0;
    check("t1_armed", 32'(armed), 32'd1);
    check("t1_entry", 32'(entry), 32'd0);
    check("t1_alarm", 32'(alarm), 32'd0);

    // 2: instant zone raises alarm on the 7th edge
    instant_mask = 4'b0001;
    sensor       = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      cycle();
      if (e == 6) check("t2_alarm_e6", 32'(alarm), 32'd0);
    end
    check("t2_alarm_e7", 32'(alarm), 32'd1);
    check("t2_zone", 32'(zone), 32'h1);

    // 3a: delayed zone enters ENTRY at edge 7, disarmed before edge 23
    release_all();
    arm_sys();
    instant_mask = 4'b0000;
    sensor       = 4'b0100;
    for (int e = 1; e <= 25; e++) begin
      cycle();
      if (e == 6)  check("t3_entry_e6", 32'(entry), 32'd0);
      if (e == 7)  check("t3_entry_e7", 32'(entry), 32'd1);
      if (e == 19) disarm = 1'b1;
      if (e == 22) check("t3_disarmed", 32'(armed), 32'd0);
    end
    check("t3_no_alarm", 32'(alarm), 32'd0);
    check("t3_zone_clr", 32'(zone), 32'h0);

    // 3b: same zone left alone alarms at edge 23
    release_all();
    arm_sys();
    sensor = 4'b0100;
    for (int e = 1; e <= 23; e++) begin
      cycle();
      if (e == 22) check("t3b_alarm_e22", 32'(alarm), 32'd0);
    end
    check("t3b_alarm_e23", 32'(alarm), 32'd1);
    check("t3b_zone", 32'(zone), 32'h4);

    // 4: 3-high/1-low pulses never debounce
    release_all();
    arm_sys();
    instant_mask = 4'b0010;
    for (int e = 0; e < 40; e++) begin
      sensor = ((e % 4) != 3) ? 4'b0010 : 4'b0000;
      cycle();
    end
    sensor = '0;
    check("t4_alarm", 32'(alarm), 32'd0);
    check("t4_armed", 32'(armed), 32'd1);

    // 5a: arming is refused while a zone is active
    release_all();
    sensor = 4'b1000;
    repeat (8) cycle();
    arm_sys();
    repeat (2) cycle();
    check("t5_refused", 32'(armed), 32'd0);

    // 5b: arm and disarm together from ALARM -> DISARMED, zone cleared
    release_all();
    arm_sys();
    instant_mask = 4'b0001;
    sensor       = 4'b0001;
    repeat (7) cycle();
    check("t5_alarm", 32'(alarm), 32'd1);
    sensor = '0;
    arm    = 1'b1;
    disarm = 1'b1;
    repeat (3) cycle();
    check("t5_both_alarm", 32'(alarm), 32'd0);
    check("t5_both_zone",  32'(zone),  32'h0);
    check("t5_both_armed", 32'(armed), 32'd0);
    release_all();

    // 6: asynchronous reset in ALARM clears outputs before the next edge
    arm_sys();
    sensor = 4'b0001;
    repeat (7) cycle();
    check("t6_alarm_pre", 32'(alarm), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_alarm", 32'(alarm), 32'd0);
    check("t6_zone",  32'(zone),  32'h0);
    check("t6_armed", 32'(armed), 32'd0);
    model_reset();
    compare_all();
    sensor = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized phase: sparse sensor activity, occasional arm/disarm.
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) instant_mask = N'($urandom);
      for (int i = 0; i < N; i++) begin
        if (sensor[i]) sensor[i] = ($urandom_range(3) != 0);
        else           sensor[i] = ($urandom_range(29) == 0);
      end
      arm    = ($urandom_range(7) == 0);
      disarm = ($urandom_range(59) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
